pll_lock_supervisor: RTL and testbench

Sits directly downstream of the calibrated PLL wrapper (pll_27 and its siblings). It runs on the 50 MHz init clock and owns the PLL reset. It qualifies the PLL lock output, retries the PLL when lock times out, and releases staged resets in order: system reset first, then application reset once DDR3 calibration reports done. Loss of lock or a forced relock tears both resets down and restarts the sequence.

---
 rtl/pll_sup_pkg.sv | 29 ++
 rtl/pll_lock_supervisor_sync2.sv | 33 +++
 rtl/pll_lock_supervisor.sv | 185 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor slice.
//   pllSupState_e : supervisor FSM states (encoding visible on the debug port)
//   RELOCK_MAX    : saturation value of the relock counter
//   maxOf3        : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLLRST    = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      SYS_UP    = 3'd3,
      RUN       = 3'd4
   } pllSupState_e;

   localparam logic [7:0] RELOCK_MAX = 8'd255;

   // Largest of three cycle limits; the counter must hold the biggest one.
   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_sync2
// Two-flop synchroniser for a single asynchronous level into the clk domain.
//   clk_i    : destination clock
//   resetn_i : synchronous active-low clear, both flops go to 0
//   d_i      : asynchronous input level
//   q_o      : synchronised level, two clk edges after d_i settles
// ---------------------------------------------------------------------------
module sync2 (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a full cycle to resolve
   // metastability before the level is used by any logic.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Owns the PLL reset, qualifies the PLL lock and releases staged resets:
// system reset once lock has been stable, application reset once DDR3
// calibration is done. Lock loss or a forced relock restarts everything.
//   clk_i            : 50 MHz init clock
//   resetn_i         : synchronous active-low block reset
//   pll_lock_i       : PLL lock, asynchronous
//   calib_done_i     : DDR3 calibration done, asynchronous
//   force_relock_i   : single-cycle relock request, clk domain
//   pll_reset_o      : PLL reset, active-high
//   sys_resetn_o     : core/DDR controller reset, active-low
//   app_resetn_o     : application reset, active-low
//   locked_o         : high while in SYS_UP or RUN
//   state_o          : current FSM state, for debug
//   relock_count_o   : PLL retries plus lock losses, saturating at 255
// ---------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 64,
   parameter int STABLE_CYCLES  = 1000,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       pll_lock_i,
   input  logic       calib_done_i,
   input  logic       force_relock_i,
   output logic       pll_reset_o,
   output logic       sys_resetn_o,
   output logic       app_resetn_o,
   output logic       locked_o,
   output logic [2:0] state_o,
   output logic [7:0] relock_count_o
);

   localparam int CNT_W = $clog2(maxOf3(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES) + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   pllSupState_e     state_q;
   pllSupState_e     state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       relockCnt_q;
   logic [7:0]       relockCnt_d;
   logic             relockEvent;

   logic             pllReset_q;
   logic             sysResetn_q;
   logic             appResetn_q;
   logic             locked_q;

   logic             lockS;
   logic             calibS;

   sync2 u_syncLock (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .d_i      (pll_lock_i),
      .q_o      (lockS)
   );

   sync2 u_syncCalib (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .d_i      (calib_done_i),
      .q_o      (calibS)
   );

   // Next-state logic. A forced relock outranks every other transition, but
   // is meaningless while the PLL is already being reset, so PLLRST keeps
   // counting through it. One shared counter serves all timed states and is
   // cleared on every state change.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      relockEvent = 1'b0;

      if (force_relock_i && (state_q != PLLRST)) begin
         state_d     = PLLRST;
         cnt_d       = CNT_ZERO;
         relockEvent = 1'b1;
      end else begin
         unique case (state_q)
            PLLRST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (lockS) begin
                  state_d = STABLE;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d     = PLLRST;
                  cnt_d       = CNT_ZERO;
                  relockEvent = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            STABLE: begin
               if (!lockS) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = SYS_UP;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            SYS_UP: begin
               cnt_d = CNT_ZERO;
               if (!lockS) begin
                  state_d     = PLLRST;
                  relockEvent = 1'b1;
               end else if (calibS) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               cnt_d = CNT_ZERO;
               if (!lockS) begin
                  state_d     = PLLRST;
                  relockEvent = 1'b1;
               end
            end
            default: begin
               state_d = PLLRST;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // Relock counter saturates rather than wrapping so a flapping PLL never
   // looks healthy again on the debug port.
   always_comb begin
      relockCnt_d = relockCnt_q;
      if (relockEvent && (relockCnt_q != RELOCK_MAX)) begin
         relockCnt_d = relockCnt_q + 8'd1;
      end
   end

   // State, counter and outputs share one register stage. Outputs decode the
   // next state so they switch on the very edge the state does, which keeps
   // raw lock fall to reset assertion within three clk cycles.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q     <= PLLRST;
         cnt_q       <= CNT_ZERO;
         relockCnt_q <= 8'd0;
         pllReset_q  <= 1'b1;
         sysResetn_q <= 1'b0;
         appResetn_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         relockCnt_q <= relockCnt_d;
         pllReset_q  <= (state_d == PLLRST);
         sysResetn_q <= (state_d == SYS_UP) || (state_d == RUN);
         appResetn_q <= (state_d == RUN);
         locked_q    <= (state_d == SYS_UP) || (state_d == RUN);
      end
   end

   assign pll_reset_o    = pllReset_q;
   assign sys_resetn_o   = sysResetn_q;
   assign app_resetn_o   = appResetn_q;
   assign locked_o       = locked_q;
   assign state_o        = state_q;
   assign relock_count_o = relockCnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with short cycle limits
// (PLL reset 4, stable window 16, lock timeout 100).
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

   localparam int PLL_RST_CYCLES = 4;
   localparam int STABLE_CYCLES  = 16;
   localparam int TIMEOUT_CYCLES = 100;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       pllLock = 1'b0;
   logic       calibDone = 1'b0;
   logic       forceRelock = 1'b0;
   logic       pllReset;
   logic       sysResetn;
   logic       appResetn;
   logic       locked;
   logic [2:0] state;
   logic [7:0] relockCount;

   int checkCount = 0;
   int errorCount = 0;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_i          (clk),
      .resetn_i       (resetn),
      .pll_lock_i     (pllLock),
      .calib_done_i   (calibDone),
      .force_relock_i (forceRelock),
      .pll_reset_o    (pllReset),
      .sys_resetn_o   (sysResetn),
      .app_resetn_o   (appResetn),
      .locked_o       (locked),
      .state_o        (state),
      .relock_count_o (relockCount)
   );

   // 50 MHz init clock.
   always #10 clk = ~clk;

   // Advance one clock and settle just after the edge, where outputs are
   // sampled and new inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive every DUT input at once.
   task automatic applyStimulus(input logic rn, input logic lock,
                                input logic calib, input logic force_);
      resetn      = rn;
      pllLock     = lock;
      calibDone   = calib;
      forceRelock = force_;
   endtask

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Bounded wait for a given state; running out of budget shows up as a
   // failed state comparison.
   task automatic waitState(input logic [2:0] target, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (state == target) break;
      end
      checkOutput(tag, state, target);
   endtask

   int n;
   int rises;
   int rise1;
   int rise2;
   logic prevReset;

   initial begin
      // Reset values.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("rstPllReset", pllReset, 1);
      checkOutput("rstSysResetn", sysResetn, 0);
      checkOutput("rstAppResetn", appResetn, 0);
      checkOutput("rstLocked", locked, 0);
      checkOutput("rstState", state, 0);
      checkOutput("rstRelock", relockCount, 0);

      // Bring-up: PLL reset lasts four edges after release.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (!pllReset) break;
      end
      checkOutput("pllRstLen", n, 4);
      checkOutput("waitLockState", state, 1);

      // Lock arrives: 2 sync + 1 to STABLE, 16 more to SYS_UP.
      repeat (5) tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("stableEntry", state, 2);
      repeat (15) tick();
      checkOutput("sysHeldInStable", sysResetn, 0);
      tick();
      checkOutput("sysRelease", sysResetn, 1);
      checkOutput("sysUpState", state, 3);
      checkOutput("appHeldSysUp", appResetn, 0);
      checkOutput("lockedSysUp", locked, 1);
      checkOutput("relockAfterBringup", relockCount, 0);

      // Calibration done: application reset lifts three edges later.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (2) tick();
      checkOutput("appHeldDuringSync", appResetn, 0);
      tick();
      checkOutput("appRelease", appResetn, 1);
      checkOutput("runState", state, 4);
      checkOutput("lockedRun", locked, 1);

      // Reset from RUN, then lock never comes: timeouts at ticks 104 and 208.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("midRunResetState", state, 0);
      checkOutput("midRunResetSys", sysResetn, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      prevReset = pllReset;
      rises = 0;
      rise1 = 0;
      rise2 = 0;
      for (int i = 1; i <= 250; i++) begin
         tick();
         if (pllReset && !prevReset) begin
            rises++;
            if (rises == 1) rise1 = i;
            else if (rises == 2) rise2 = i;
         end
         prevReset = pllReset;
      end
      checkOutput("timeoutPulses", rises, 2);
      checkOutput("timeout1Tick", rise1, 104);
      checkOutput("timeout2Tick", rise2, 208);
      checkOutput("timeoutRelock", relockCount, 2);
      checkOutput("timeoutEndState", state, 1);

      // Back to RUN, then a one-cycle lock drop.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      waitState(3'd4, 100, "reachRun1");
      checkOutput("relockBeforeDrop", relockCount, 2);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("sysStillUpInSync", sysResetn, 1);
      tick();
      checkOutput("dropSysResetn", sysResetn, 0);
      checkOutput("dropAppResetn", appResetn, 0);
      checkOutput("dropPllReset", pllReset, 1);
      checkOutput("dropRelock", relockCount, 3);
      waitState(3'd4, 100, "replayRun");
      checkOutput("replayRelock", relockCount, 3);

      // Forced relock, then lock glitch at cycle 10 of STABLE.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("forceState", state, 0);
      checkOutput("forceRelock", relockCount, 4);
      waitState(3'd2, 20, "reachStable");
      repeat (9) tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      checkOutput("stableDropState", state, 1);
      checkOutput("stableDropRelock", relockCount, 4);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (18) tick();
      checkOutput("windowRestartHeld", sysResetn, 0);
      tick();
      checkOutput("windowRestartRelease", sysResetn, 1);

      // Force on the same edge as a lock loss counts once.
      waitState(3'd4, 20, "reachRun3");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) tick();
      checkOutput("runBeforeCoincident", state, 4);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("coincidentRelock", relockCount, 5);
      checkOutput("coincidentState", state, 0);

      // Force inside PLLRST neither counts nor restarts the counter.
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("pllRstIgnoresForce", state, 0);
      tick();
      checkOutput("pllRstNotRestarted", state, 1);
      checkOutput("pllRstForceRelock", relockCount, 5);

      // 300 forced relocks from WAIT_LOCK: saturate at 255.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
         tick();
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
         if (i == 248) checkOutput("relockBelowMax", relockCount, 254);
         repeat (4) tick();
      end
      checkOutput("relockSaturated", relockCount, 255);
      checkOutput("saturateEndState", state, 1);

      // Reset mid-WAIT_LOCK returns everything on that edge.
      repeat (3) tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("lateRstPllReset", pllReset, 1);
      checkOutput("lateRstSys", sysResetn, 0);
      checkOutput("lateRstApp", appResetn, 0);
      checkOutput("lateRstLocked", locked, 0);
      checkOutput("lateRstState", state, 0);
      checkOutput("lateRstRelock", relockCount, 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
